mult_div_unit: RTL

- E-stage multiply/divide unit, plus the HI/LO register pair.
- Responder side of the start/busy handshake. The hazard controller drives start and stalls D while busy or start is high; this block consumes start and produces busy.
- Sits beside the ALU in the datapath. It takes the forwarded ALU operands and returns the HI or LO value to the E-stage result mux for mfhi/mflo.

---
 rtl/mult_div_unit_pkg.sv | 47 ++++
 rtl/mult_div_unit_md_compute.sv | 68 ++++++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// Module  : mult_div_unit_pkg
// Brief   : Shared op codes, latency defaults and FSM states for the MDU.
//           Optional macro: MDU_MADD_EN (adds MADD/MADDU launch ops).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_launch(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: md_is_launch = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU:                  md_is_launch = 1'b1;
`endif
            default:                            md_is_launch = 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        md_is_div = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_md_compute.sv
// ============================================================================
// Module  : md_compute
// Brief   : Combinational 32x32 multiply / divide producing {hi,lo}.
//           Optional macro: MDU_MADD_EN (MADD/MADDU return the raw product).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_compute
    import mult_div_unit_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        div_by_zero_o
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_b_safe;
    logic signed [32:0] w_sa;
    logic signed [32:0] w_sb;
    logic signed [32:0] w_sq;
    logic signed [32:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic               w_unused;

    assign w_prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign w_prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Divisor forced to 1 on zero so the dividers never see x; result is discarded.
    assign w_b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
    // 33-bit signed keeps -2^31 / -1 representable before truncation.
    assign w_sa     = $signed({a_i[31], a_i});
    assign w_sb     = $signed({w_b_safe[31], w_b_safe});
    assign w_sq     = w_sa / w_sb;
    assign w_sr     = w_sa % w_sb;
    assign w_uq     = a_i / w_b_safe;
    assign w_ur     = a_i % w_b_safe;
    assign w_unused = ^{w_sq[32], w_sr[32]};

    always_comb begin
        res_o         = 64'd0;
        div_by_zero_o = 1'b0;
        case (op_i)
            MD_MULT:  res_o = w_prod_s;
            MD_MULTU: res_o = w_prod_u;
            MD_DIV: begin
                res_o         = {w_sr[31:0], w_sq[31:0]};
                div_by_zero_o = (b_i == 32'd0);
            end
            MD_DIVU: begin
                res_o         = {w_ur, w_uq};
                div_by_zero_o = (b_i == 32'd0);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  res_o = w_prod_s;
            MD_MADDU: res_o = w_prod_u;
`endif
            default:  res_o = 64'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module  : mult_div_unit
// Brief   : E-stage multiply/divide unit with HI/LO and start/busy handshake.
//           Optional macro: MDU_MADD_EN (multiply-accumulate into {HI,LO}).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mult_div_sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q, pend_d;
    logic               dbz_q, dbz_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        w_res;
    logic               w_dbz;
`ifdef MDU_MADD_EN
    logic               acc_q, acc_d;
`endif

    md_compute u_md_compute (
        .op_i          (mult_div_sel),
        .a_i           (A),
        .b_i           (B),
        .res_o         (w_res),
        .div_by_zero_o (w_dbz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 64'd0;
            dbz_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MDU_MADD_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_MADD_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && md_is_launch(mult_div_sel)) begin
                    pend_d  = w_res;
                    dbz_d   = w_dbz;
                    cnt_d   = md_is_div(mult_div_sel) ? CNT_W'(DIV_CYCLES)
                                                      : CNT_W'(MULT_CYCLES);
                    state_d = RUN;
`ifdef MDU_MADD_EN
                    acc_d   = (mult_div_sel == MD_MADD) || (mult_div_sel == MD_MADDU);
`endif
                end else if (mult_div_sel == MD_MTHI) begin
                    hi_d = A;
                end else if (mult_div_sel == MD_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!dbz_q) begin
`ifdef MDU_MADD_EN
                        // Accumulate base is whatever HI/LO hold at commit.
                        {hi_d, lo_d} = acc_q ? ({hi_q, lo_q} + pend_q) : pend_q;
`else
                        {hi_d, lo_d} = pend_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        case (mult_div_sel)
            MD_MFHI: MD_out = hi_q;
            MD_MFLO: MD_out = lo_q;
            default: MD_out = 32'd0;
        endcase
    end

endmodule

`default_nettype wire
